gpmc_wb_bridge: RTL and testbench
=================================

# gpmc_wb_bridge

Upstream bus master for BeagleWire FPGA peripherals: converts asynchronous, address/data-multiplexed GPMC accesses from the ARM host into single-clock transfer strobes on the team's peripheral bus. Sits between the top-level GPMC pins (tristate handled by top-level SB_IO) and peripheral slaves such as the LED controller. Handles synchronisation, address latching, write strobing and read-data return.

## Interface
- ADDR_WIDTH, 4: width of wbm_address; low bits of latched GPMC address.
- DATA_WIDTH, 16: bus data width; must equal GPMC AD width.
- clk  in  1  system clock; all logic in this domain.
- reset  in  1  synchronous, active-low.
- gpmc_ad_in  in  DATA_WIDTH  AD bus input from pin buffer.
- gpmc_ad_out  out  DATA_WIDTH  read data to pin buffer.
- gpmc_ad_oe  out  1  pin output enable; 1 = FPGA drives AD.
- gpmc_csn  in  1  chip select, active-low, asynchronous.
- gpmc_advn  in  1  address valid, active-low, asynchronous.
- gpmc_wein  in  1  write enable, active-low, asynchronous.
- gpmc_oen  in  1  output enable, active-low, asynchronous.
- wbm_address  out  ADDR_WIDTH  transfer address.
- wbm_writedata  out  DATA_WIDTH  write data.
- wbm_readdata  in  DATA_WIDTH  slave read data, registered by slave.
- wbm_write  out  1  1 = write, 0 = read.
- wbm_cycle  out  1  transfer strobe; idles high, low for exactly one clk per transfer.

## Operation
- Bus convention: slave acts on the clk where wbm_cycle=0; read data is valid on wbm_readdata one clk after the strobe. No ack consumed; latency fixed.
- All four GPMC controls pass through 2-FF synchronisers (reset value 1); gpmc_ad_in through a matching 2-FF pipeline (reset 0) so data and control stay aligned. Edge detect on synchronised outputs (csn_s, advn_s, wein_s, oen_s, ad_s).
- Only events with csn_s=0 are acted on.
- FSM states: IDLE, ADDR, WR_CYC, RD_CYC, RD_CAP, RD_DRIVE.
- IDLE: advn_s rising with csn_s=0 -> latch ad_s[ADDR_WIDTH-1:0] into wbm_address, go ADDR.
- ADDR: wein_s rising -> latch ad_s into wbm_writedata, go WR_CYC; oen_s falling -> RD_CYC; advn_s rising -> relatch address, stay; csn_s=1 -> IDLE.
- WR_CYC (1 clk): wbm_cycle=0, wbm_write=1 -> ADDR.
- RD_CYC (1 clk): wbm_cycle=0, wbm_write=0 -> RD_CAP.
- RD_CAP (1 clk): gpmc_ad_out <= wbm_readdata -> RD_DRIVE.
- RD_DRIVE: gpmc_ad_oe=1; oen_s=1 -> ADDR; csn_s=1 -> IDLE; oe drops on the transition clk.
- Upper address bits above ADDR_WIDTH ignored (no decode here).
- Simultaneous wein_s rising and oen_s falling in ADDR: write taken, read ignored (illegal host behaviour).
- csn_s rising during WR_CYC/RD_CYC/RD_CAP: current state completes its single clk, then IDLE; no drive of AD.
- Reset mid-operation: FSM to IDLE at that clk; no strobe issued or completed.
- Reset values: wbm_cycle=1, wbm_write=0, wbm_address=0, wbm_writedata=0, gpmc_ad_out=0, gpmc_ad_oe=0.

## Timing
- All outputs registered.
- Write: WE pin rising -> wbm_cycle low 3 clk later (2 sync + 1).
- Read: OE pin falling -> gpmc_ad_oe high 5 clk later, data valid same clk. Host GPMC access time must be configured ≥ 7 clk.
- OE pin rising -> gpmc_ad_oe low within 3 clk.
- Minimum GPMC pulse width per control: 2 clk. Address/data must be stable 2 clk before the qualifying edge.

## Structure
- Package gpmc_wb_pkg: FSM state enum, sync depth constant (2), read-latency constant.
- Sub-module sync_edge: 2-FF synchroniser with parameterised reset value plus registered rise/fall pulse outputs; one instance per GPMC control.

## Test plan
- Write addr 0x0000, data 0x000A -> one clk wbm_cycle=0, wbm_write=1, wbm_address=0, wbm_writedata=0x000A; with LED slave attached, led=4'b1010.
- Read addr 0 after above -> wbm_cycle=0, wbm_write=0 once; gpmc_ad_oe=1 and gpmc_ad_out=0x000A exactly 5 clk after OE fall; oe low ≤3 clk after OE rise.
- WE/OE pulses with gpmc_csn=1 -> wbm_cycle stays 1, gpmc_ad_oe stays 0.
- Two back-to-back writes (0x0003, 0x0005) without CS deassert, new ADV each -> two strobes, writedata 0x0003 then 0x0005.
- CS raised during RD_DRIVE -> gpmc_ad_oe falls on csn_s rising clk, FSM IDLE.
- reset=0 asserted in RD_DRIVE -> next clk gpmc_ad_oe=0, wbm_cycle=1, all outputs at reset values.

Source files
------------

// File: rtl/gpmc_wb_pkg.sv
// Shared types and constants for the GPMC-to-peripheral-bus bridge.
package gpmc_wb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned SYNC_DEPTH     = 2;
  // OE pin fall to AD drive: synchroniser stages + strobe + capture + drive
  localparam int unsigned RD_LATENCY     = SYNC_DEPTH + 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WR_CYC,
    RD_CYC,
    RD_CAP,
    RD_DRIVE
  } state_e;

endpackage

// File: rtl/gpmc_wb_bridge_if.sv
// GPMC pin-side and peripheral-bus signals of the bridge, bundled with
// master (bridge) and slave (pins/peripheral side) views.
interface gpmc_wb_bridge_if #(
  parameter int unsigned ADDR_WIDTH = gpmc_wb_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = gpmc_wb_pkg::DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] gpmc_ad_in;
  logic [DATA_WIDTH-1:0] gpmc_ad_out;
  logic                  gpmc_ad_oe;
  logic                  gpmc_csn;
  logic                  gpmc_advn;
  logic                  gpmc_wein;
  logic                  gpmc_oen;
  logic [ADDR_WIDTH-1:0] wbm_address;
  logic [DATA_WIDTH-1:0] wbm_writedata;
  logic [DATA_WIDTH-1:0] wbm_readdata;
  logic                  wbm_write;
  logic                  wbm_cycle;

  modport master (
    input  gpmc_ad_in, gpmc_csn, gpmc_advn, gpmc_wein, gpmc_oen, wbm_readdata,
    output gpmc_ad_out, gpmc_ad_oe, wbm_address, wbm_writedata, wbm_write, wbm_cycle
  );

  modport slave (
    output gpmc_ad_in, gpmc_csn, gpmc_advn, gpmc_wein, gpmc_oen, wbm_readdata,
    input  gpmc_ad_out, gpmc_ad_oe, wbm_address, wbm_writedata, wbm_write, wbm_cycle
  );

endinterface

// File: rtl/gpmc_wb_bridge_sync_edge.sv
// Multi-stage synchroniser for one asynchronous GPMC control, with registered
// rise/fall pulses aligned to the synchronised level.
module sync_edge
  import gpmc_wb_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;

  // Pulses are computed one stage early so they coincide with q changing
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= {SYNC_DEPTH{RST_VAL}};
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
      rise   <= sync_q[SYNC_DEPTH-2] & ~sync_q[SYNC_DEPTH-1];
      fall   <= ~sync_q[SYNC_DEPTH-2] & sync_q[SYNC_DEPTH-1];
    end
  end

  assign q = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/gpmc_wb_bridge.sv
// GPMC host to single-strobe peripheral bus bridge: synchronises the async
// GPMC controls, latches address/data, issues one-clk strobes and returns read data.
module gpmc_wb_bridge
  import gpmc_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic              clk,
  input logic              reset,
  gpmc_wb_bridge_if.master bus
);

  logic csn_s, csn_rise, csn_fall;
  logic advn_s, advn_rise, advn_fall;
  logic wein_s, wein_rise, wein_fall;
  logic oen_s, oen_rise, oen_fall;
  logic unused_edges;

  logic [DATA_WIDTH-1:0] ad_meta, ad_s;

  state_e                state_q, state_d;
  logic                  cycle_q, cycle_d;
  logic                  write_q, write_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] ad_out_q, ad_out_d;

  sync_edge #(.RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .reset(reset), .d(bus.gpmc_csn),
    .q(csn_s), .rise(csn_rise), .fall(csn_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_sync_advn (
    .clk(clk), .reset(reset), .d(bus.gpmc_advn),
    .q(advn_s), .rise(advn_rise), .fall(advn_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_sync_wein (
    .clk(clk), .reset(reset), .d(bus.gpmc_wein),
    .q(wein_s), .rise(wein_rise), .fall(wein_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_sync_oen (
    .clk(clk), .reset(reset), .d(bus.gpmc_oen),
    .q(oen_s), .rise(oen_rise), .fall(oen_fall)
  );

  // Levels and edges the FSM does not act on
  assign unused_edges = ^{csn_rise, csn_fall, advn_s, advn_fall, wein_s, wein_fall, oen_rise};

  // AD pipeline matches the control synchroniser depth so bus and strobes stay aligned
  always_ff @(posedge clk) begin
    if (!reset) begin
      ad_meta <= '0;
      ad_s    <= '0;
    end else begin
      ad_meta <= bus.gpmc_ad_in;
      ad_s    <= ad_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cycle_q  <= 1'b1;
      write_q  <= 1'b0;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ad_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      write_q  <= write_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ad_out_q <= ad_out_d;
    end
  end

  // Next state; strobe/oe are decoded from the next state so they register with it
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ad_out_d = ad_out_q;

    unique case (state_q)
      IDLE: begin
        if (!csn_s && advn_rise) begin
          addr_d  = ad_s[ADDR_WIDTH-1:0];
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (csn_s) begin
          state_d = IDLE;
        end else if (wein_rise) begin
          wdata_d = ad_s;
          state_d = WR_CYC;
        end else if (oen_fall) begin
          state_d = RD_CYC;
        end else if (advn_rise) begin
          addr_d = ad_s[ADDR_WIDTH-1:0];
        end
      end
      WR_CYC:   state_d = csn_s ? IDLE : ADDR;
      RD_CYC:   state_d = csn_s ? IDLE : RD_CAP;
      RD_CAP: begin
        ad_out_d = bus.wbm_readdata;
        state_d  = csn_s ? IDLE : RD_DRIVE;
      end
      RD_DRIVE: begin
        if (csn_s) begin
          state_d = IDLE;
        end else if (oen_s) begin
          state_d = ADDR;
        end
      end
      default:  state_d = IDLE;
    endcase

    cycle_d = !((state_d == WR_CYC) || (state_d == RD_CYC));
    write_d = (state_d == WR_CYC);
    oe_d    = (state_d == RD_DRIVE);
  end

  assign bus.wbm_cycle     = cycle_q;
  assign bus.wbm_write     = write_q;
  assign bus.wbm_address   = addr_q;
  assign bus.wbm_writedata = wdata_q;
  assign bus.gpmc_ad_out   = ad_out_q;
  assign bus.gpmc_ad_oe    = oe_q;

endmodule

// File: tb/tb_gpmc_wb_bridge.sv
// Bench for gpmc_wb_bridge: drives GPMC pin sequences, models a register-file
// peripheral, and checks strobes, latencies and read return.
module tb_gpmc_wb_bridge;

  typedef struct packed {
    logic        wr;
    logic [3:0]  a;
    logic [15:0] d;
  } obs_t;

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [15:0] d;
    bit          cs_on;
    int          exp_n;
    logic [3:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  obs_t        obs_q[$];
  logic [15:0] smem    [16] = '{default: 16'h0000};
  logic [15:0] ref_mem [16] = '{default: 16'h0000};
  logic [3:0]  led;
  vec_t        vecs    [9];

  gpmc_wb_bridge_if bus ();

  gpmc_wb_bridge dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Register-file peripheral: acts on the strobe clk, read data one clk later
  always @(posedge clk) begin
    if (bus.wbm_cycle === 1'b0) begin
      if (bus.wbm_write) smem[bus.wbm_address] <= bus.wbm_writedata;
      else               bus.wbm_readdata      <= smem[bus.wbm_address];
    end
  end
  assign led = smem[0][3:0];

  always @(negedge clk) begin
    if (bus.wbm_cycle === 1'b0)
      obs_q.push_back('{bus.wbm_write, bus.wbm_address, bus.wbm_writedata});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".cycle"},  32'(bus.wbm_cycle),     32'd1);
    check({tag, ".write"},  32'(bus.wbm_write),     32'd0);
    check({tag, ".addr"},   32'(bus.wbm_address),   32'd0);
    check({tag, ".wdata"},  32'(bus.wbm_writedata), 32'd0);
    check({tag, ".ad_out"}, 32'(bus.gpmc_ad_out),   32'd0);
    check({tag, ".oe"},     32'(bus.gpmc_ad_oe),    32'd0);
  endtask

  task automatic addr_phase(input logic [15:0] a);
    bus.gpmc_ad_in = a;
    bus.gpmc_advn  = 1'b0;
    step(3);
    bus.gpmc_advn  = 1'b1;
    step(3);
  endtask

  // lat: negedges from WE rise until the strobe is seen, -1 if never
  task automatic wr_phase(input logic [15:0] d, output int lat);
    bus.gpmc_ad_in = d;
    step(3);
    bus.gpmc_wein = 1'b0;
    step(3);
    bus.gpmc_wein = 1'b1;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (bus.wbm_cycle === 1'b0 && lat < 0) lat = k;
    end
  endtask

  task automatic rd_phase(output int lat, output logic [15:0] rd, output int lat2);
    bus.gpmc_oen = 1'b0;
    lat = -1;
    rd  = '0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (bus.gpmc_ad_oe === 1'b1 && lat < 0) begin
        lat = k;
        rd  = bus.gpmc_ad_out;
      end
    end
    bus.gpmc_oen = 1'b1;
    lat2 = -1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (bus.gpmc_ad_oe === 1'b0 && lat2 < 0) lat2 = k;
    end
  endtask

  task automatic xfer(input string tag, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      input bit cs_on, input int exp_n, input logic [3:0] exp_addr,
                      input logic [15:0] exp_data);
    int          lat, lat2;
    logic [15:0] rd;
    lat2 = -1;
    rd   = '0;
    obs_q.delete();
    bus.gpmc_csn = ~cs_on;
    step(2);
    addr_phase(a);
    if (wr) wr_phase(d, lat);
    else    rd_phase(lat, rd, lat2);
    bus.gpmc_csn = 1'b1;
    step(4);
    if (wr && cs_on) ref_mem[a[3:0]] = d;
    check({tag, ".nstrobe"}, 32'(obs_q.size()), 32'(exp_n));
    if (exp_n == 1 && obs_q.size() == 1) begin
      check({tag, ".write"}, 32'(obs_q[0].wr), 32'(wr));
      check({tag, ".addr"},  32'(obs_q[0].a),  32'(exp_addr));
      if (wr) check({tag, ".wdata"}, 32'(obs_q[0].d), 32'(exp_data));
    end
    if (wr) begin
      check({tag, ".cyc_lat"}, 32'(lat), (exp_n == 1) ? 32'd3 : 32'hFFFF_FFFF);
    end else begin
      check({tag, ".oe_lat"}, 32'(lat), (exp_n == 1) ? 32'd5 : 32'hFFFF_FFFF);
      if (exp_n == 1) begin
        check({tag, ".rdata"},  32'(rd), 32'(exp_data));
        check({tag, ".oe_off"}, 32'(lat2 >= 1 && lat2 <= 3), 32'd1);
      end
    end
  endtask

  initial begin
    int          lat, lat2;
    logic [15:0] rd;
    bit          saw_oe;

    //        wr    addr      data      cs   n  eaddr  edata
    vecs[0] = '{1'b1, 16'h0000, 16'h000A, 1'b1, 1, 4'h0, 16'h000A};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1, 4'h0, 16'h000A};
    vecs[2] = '{1'b1, 16'hFFF3, 16'h1234, 1'b1, 1, 4'h3, 16'h1234};
    vecs[3] = '{1'b0, 16'h0003, 16'h0000, 1'b1, 1, 4'h3, 16'h1234};
    vecs[4] = '{1'b1, 16'h0005, 16'hBEEF, 1'b0, 0, 4'h0, 16'h0000};
    vecs[5] = '{1'b0, 16'h0005, 16'h0000, 1'b0, 0, 4'h0, 16'h0000};
    vecs[6] = '{1'b0, 16'h0015, 16'h0000, 1'b1, 1, 4'h5, 16'h0000};
    vecs[7] = '{1'b1, 16'h000F, 16'hFFFF, 1'b1, 1, 4'hF, 16'hFFFF};
    vecs[8] = '{1'b0, 16'h00AF, 16'h0000, 1'b1, 1, 4'hF, 16'hFFFF};

    reset          = 1'b0;
    bus.gpmc_csn   = 1'b1;
    bus.gpmc_advn  = 1'b1;
    bus.gpmc_wein  = 1'b1;
    bus.gpmc_oen   = 1'b1;
    bus.gpmc_ad_in = 16'h0000;
    step(4);
    check_reset_vals("reset");
    reset = 1'b1;
    step(4);

    for (int i = 0; i < 9; i++)
      xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].cs_on,
           vecs[i].exp_n, vecs[i].exp_addr, vecs[i].exp_data);
    check("led", 32'(led), 32'hA);

    // Back-to-back writes in one CS window, new ADV each
    obs_q.delete();
    bus.gpmc_csn = 1'b0;
    step(2);
    addr_phase(16'h0001);
    wr_phase(16'h0003, lat);
    addr_phase(16'h0002);
    wr_phase(16'h0005, lat);
    bus.gpmc_csn = 1'b1;
    step(4);
    ref_mem[1] = 16'h0003;
    ref_mem[2] = 16'h0005;
    check("b2b.nstrobe", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("b2b.wdata0", 32'(obs_q[0].d), 32'h0003);
      check("b2b.wdata1", 32'(obs_q[1].d), 32'h0005);
      check("b2b.addr1",  32'(obs_q[1].a), 32'h2);
    end

    // WE rise and OE fall seen together: write wins, no read
    obs_q.delete();
    saw_oe = 1'b0;
    bus.gpmc_csn = 1'b0;
    step(2);
    addr_phase(16'h0007);
    bus.gpmc_ad_in = 16'h0077;
    step(3);
    bus.gpmc_wein = 1'b0;
    step(3);
    bus.gpmc_wein = 1'b1;
    bus.gpmc_oen  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (bus.gpmc_ad_oe === 1'b1) saw_oe = 1'b1;
    end
    bus.gpmc_oen = 1'b1;
    bus.gpmc_csn = 1'b1;
    step(4);
    ref_mem[7] = 16'h0077;
    check("simul.nstrobe", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) check("simul.write", 32'(obs_q[0].wr), 32'd1);
    check("simul.no_oe", 32'(saw_oe), 32'd0);

    // CS raised while driving read data
    bus.gpmc_csn = 1'b0;
    step(2);
    addr_phase(16'h0003);
    bus.gpmc_oen = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      step(1);
      if (bus.gpmc_ad_oe === 1'b1) lat = k;
    end
    check("csdrv.oe_on", 32'(lat), 32'd5);
    check("csdrv.data", 32'(bus.gpmc_ad_out), 32'(ref_mem[3]));
    bus.gpmc_csn = 1'b1;
    lat2 = -1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (bus.gpmc_ad_oe === 1'b0 && lat2 < 0) lat2 = k;
    end
    check("csdrv.oe_off", 32'(lat2 >= 2 && lat2 <= 3), 32'd1);
    bus.gpmc_oen = 1'b1;
    step(4);
    // Bridge must be idle now: WE pulse without a new ADV gives no strobe
    obs_q.delete();
    bus.gpmc_csn = 1'b0;
    step(2);
    bus.gpmc_wein = 1'b0;
    step(3);
    bus.gpmc_wein = 1'b1;
    step(8);
    bus.gpmc_csn = 1'b1;
    step(4);
    check("csdrv.idle", 32'(obs_q.size()), 32'd0);

    // Reset asserted while driving read data
    bus.gpmc_csn = 1'b0;
    step(2);
    addr_phase(16'h0000);
    bus.gpmc_oen = 1'b0;
    step(6);
    check("rstdrv.pre_oe", 32'(bus.gpmc_ad_oe), 32'd1);
    obs_q.delete();
    reset = 1'b0;
    step(1);
    check_reset_vals("rstdrv");
    bus.gpmc_oen = 1'b1;
    bus.gpmc_csn = 1'b1;
    step(2);
    reset = 1'b1;
    step(4);
    check("rstdrv.nstrobe", 32'(obs_q.size()), 32'd0);
    xfer("rstdrv.rd", 1'b0, 16'h0002, 16'h0000, 1'b1, 1, 4'h2, ref_mem[2]);

    // Randomised traffic against the memory model
    for (int i = 0; i < 30; i++) begin
      bit          wr, cs_on;
      logic [15:0] a, d, exp_data;
      wr       = 1'($urandom_range(0, 1));
      cs_on    = ($urandom_range(0, 7) != 0);
      a        = 16'($urandom);
      d        = 16'($urandom);
      exp_data = wr ? d : ref_mem[a[3:0]];
      xfer($sformatf("rand%0d", i), wr, a, d, cs_on, cs_on ? 1 : 0, a[3:0], exp_data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
